// File: rtl/dp_sequencer_if.sv
// Bus between the instruction sequencer and its datapath / memory side.
// The master modport is the sequencer; the slave modport is whatever drives
// instructions, memory handshakes and branch conditions.
interface dp_sequencer_if;
    // Instruction fetch handshake
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ack;
    logic [31:0] pc;

    // Data memory handshake and datapath branch conditions
    logic        mem_ready;
    logic        beq;
    logic        bneq;
    logic        bge;
    logic        blt;

    // Decoded instruction fields
    logic [4:0]  read_reg_num1;
    logic [4:0]  read_reg_num2;
    logic [4:0]  write_reg_num;
    logic [5:0]  alu_cntrl;
    logic [31:0] imm_val;
    logic [31:0] imm_val_lui;
    logic [31:0] imm_val_jump;
    logic [31:0] return_address;
    logic [3:0]  shamt;

    // Datapath control strobes
    logic        jump;
    logic        beq_cntrl;
    logic        bneq_cntrl;
    logic        bgeq_cntrl;
    logic        blt_cntrl;
    logic        lui_cntrl;
    logic        lb;
    logic        sw;
    logic        mem_to_reg;
    logic        reg_dst;
    logic        reg_write;
    logic        timer_en;
    logic        timer_reg_en;

    // Debug view of the FSM
    logic [2:0]  state;

    modport master (
        input  instr, instr_valid, mem_ready, beq, bneq, bge, blt,
        output instr_ack, pc,
        output read_reg_num1, read_reg_num2, write_reg_num, alu_cntrl,
        output imm_val, imm_val_lui, imm_val_jump, return_address, shamt,
        output jump, beq_cntrl, bneq_cntrl, bgeq_cntrl, blt_cntrl, lui_cntrl,
        output lb, sw, mem_to_reg, reg_dst, reg_write, timer_en, timer_reg_en,
        output state
    );

    modport slave (
        output instr, instr_valid, mem_ready, beq, bneq, bge, blt,
        input  instr_ack, pc,
        input  read_reg_num1, read_reg_num2, write_reg_num, alu_cntrl,
        input  imm_val, imm_val_lui, imm_val_jump, return_address, shamt,
        input  jump, beq_cntrl, bneq_cntrl, bgeq_cntrl, blt_cntrl, lui_cntrl,
        input  lb, sw, mem_to_reg, reg_dst, reg_write, timer_en, timer_reg_en,
        input  state
    );
endinterface

// File: rtl/dp_sequencer.sv
// Multi-cycle RV32I control sequencer: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Owns the PC and the instruction register; every control strobe is a
// registered FSM output, so each strobe is valid for the whole state it marks.
module dp_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           reset,
    dp_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd7
    } state_e;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpIAlu   = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpTimer  = 7'b0001011;

    state_e      state_q;
    logic        run_q;
    logic [31:0] ir_q;
    logic [31:0] pc_q;
    logic [31:0] ra_q;

    logic        jump_q;
    logic        beq_q;
    logic        bneq_q;
    logic        bgeq_q;
    logic        blt_q;
    logic        lui_q;
    logic        lb_q;
    logic        sw_q;
    logic        m2r_q;
    logic        rdst_q;
    logic        rw_q;
    logic        ten_q;
    logic        treg_q;

    // Instruction classification from the latched IR
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_r;
    logic        is_ialu;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_lui;
    logic        is_jal;
    logic        is_timer;
    logic        is_legal;
    logic        is_shift_imm;
    logic        wb_rw;

    assign opcode       = ir_q[6:0];
    assign funct3       = ir_q[14:12];
    assign is_r         = (opcode == OpR);
    assign is_ialu      = (opcode == OpIAlu);
    assign is_load      = (opcode == OpLoad);
    assign is_store     = (opcode == OpStore);
    assign is_branch    = (opcode == OpBranch);
    assign is_lui       = (opcode == OpLui);
    assign is_jal       = (opcode == OpJal);
    assign is_timer     = (opcode == OpTimer);
    assign is_legal     = is_r | is_ialu | is_load | is_store | is_branch | is_lui | is_jal |
                          is_timer;
    assign is_shift_imm = is_ialu & ((funct3 == 3'b001) | (funct3 == 3'b101));
    // x0 is hard-wired, so a write to it is simply suppressed
    assign wb_rw        = (ir_q[11:7] != 5'd0);

    // Immediates
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] imm_u;

    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    assign imm_u = {ir_q[31:12], 12'b0};

    // Branch outcome: the condition input matching funct3, sampled during EXEC
    logic br_taken;

    always_comb begin
        br_taken = 1'b0;
        unique case (funct3)
            3'b000:  br_taken = bus.beq;
            3'b001:  br_taken = bus.bneq;
            3'b101:  br_taken = bus.bge;
            3'b100:  br_taken = bus.blt;
            default: br_taken = 1'b0;
        endcase
    end

    // Capture is blocked until one clock edge has passed out of reset
    logic instr_ack;
    assign instr_ack = run_q & (state_q == StFetch) & bus.instr_valid;

    // Main sequencer: state, IR, PC and all registered control strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StFetch;
            run_q   <= 1'b0;
            ir_q    <= 32'd0;
            pc_q    <= RESET_PC;
            ra_q    <= 32'd0;
            jump_q  <= 1'b0;
            beq_q   <= 1'b0;
            bneq_q  <= 1'b0;
            bgeq_q  <= 1'b0;
            blt_q   <= 1'b0;
            lui_q   <= 1'b0;
            lb_q    <= 1'b0;
            sw_q    <= 1'b0;
            m2r_q   <= 1'b0;
            rdst_q  <= 1'b0;
            rw_q    <= 1'b0;
            ten_q   <= 1'b0;
            treg_q  <= 1'b0;
        end else begin
            run_q   <= 1'b1;
            // Strobes describe the state being entered; cleared unless re-armed below
            jump_q  <= 1'b0;
            beq_q   <= 1'b0;
            bneq_q  <= 1'b0;
            bgeq_q  <= 1'b0;
            blt_q   <= 1'b0;
            lui_q   <= 1'b0;
            lb_q    <= 1'b0;
            sw_q    <= 1'b0;
            m2r_q   <= 1'b0;
            rdst_q  <= 1'b0;
            rw_q    <= 1'b0;
            ten_q   <= 1'b0;
            treg_q  <= 1'b0;

            unique case (state_q)
                StFetch: begin
                    if (instr_ack) begin
                        ir_q    <= bus.instr;
                        ra_q    <= pc_q + 32'd4;
                        state_q <= StDecode;
                    end
                end

                StDecode: begin
                    if (!is_legal) begin
                        state_q <= StTrap;
                    end else begin
                        state_q <= StExec;
                        lui_q   <= is_lui;
                        jump_q  <= is_jal;
                        ten_q   <= is_timer;
                        treg_q  <= is_timer;
                        beq_q   <= is_branch & (funct3 == 3'b000);
                        bneq_q  <= is_branch & (funct3 == 3'b001);
                        bgeq_q  <= is_branch & (funct3 == 3'b101);
                        blt_q   <= is_branch & (funct3 == 3'b100);
                    end
                end

                StExec: begin
                    if (is_load || is_store) begin
                        state_q <= StMem;
                        lb_q    <= is_load;
                        sw_q    <= is_store;
                    end else if (is_branch) begin
                        pc_q    <= br_taken ? pc_q + imm_b : pc_q + 32'd4;
                        state_q <= StFetch;
                    end else if (is_timer) begin
                        pc_q    <= pc_q + 32'd4;
                        state_q <= StFetch;
                    end else begin
                        state_q <= StWb;
                        rw_q    <= wb_rw;
                        rdst_q  <= is_r;
                        lui_q   <= is_lui;
                        jump_q  <= is_jal;
                    end
                end

                StMem: begin
                    if (!bus.mem_ready) begin
                        lb_q <= is_load;
                        sw_q <= is_store;
                    end else if (is_load) begin
                        state_q <= StWb;
                        rw_q    <= wb_rw;
                        m2r_q   <= 1'b1;
                    end else begin
                        pc_q    <= pc_q + 32'd4;
                        state_q <= StFetch;
                    end
                end

                StWb: begin
                    pc_q    <= is_jal ? pc_q + imm_j : pc_q + 32'd4;
                    state_q <= StFetch;
                end

                StTrap: begin
                    state_q <= StTrap;
                end

                default: begin
                    state_q <= StTrap;
                end
            endcase
        end
    end

    assign bus.instr_ack      = instr_ack;
    assign bus.pc             = pc_q;
    assign bus.state          = state_q;

    assign bus.read_reg_num1  = ir_q[19:15];
    assign bus.read_reg_num2  = ir_q[24:20];
    assign bus.write_reg_num  = ir_q[11:7];
    assign bus.shamt          = ir_q[23:20];
    assign bus.alu_cntrl      = {ir_q[5], (is_r | is_shift_imm) ? ir_q[30] : 1'b0, funct3,
                                 is_branch};
    assign bus.imm_val        = is_store ? imm_s : imm_i;
    assign bus.imm_val_lui    = imm_u;
    assign bus.imm_val_jump   = imm_j;
    assign bus.return_address = ra_q;

    assign bus.jump           = jump_q;
    assign bus.beq_cntrl      = beq_q;
    assign bus.bneq_cntrl     = bneq_q;
    assign bus.bgeq_cntrl     = bgeq_q;
    assign bus.blt_cntrl      = blt_q;
    assign bus.lui_cntrl      = lui_q;
    assign bus.lb             = lb_q;
    assign bus.sw             = sw_q;
    assign bus.mem_to_reg     = m2r_q;
    assign bus.reg_dst        = rdst_q;
    assign bus.reg_write      = rw_q;
    assign bus.timer_en       = ten_q;
    assign bus.timer_reg_en   = treg_q;

endmodule

// File: tb/tb_dp_sequencer.sv
// Bench for dp_sequencer: an instruction-level model expands each issued
// instruction into its expected per-cycle output trace; one compare process
// checks the DUT against that trace every cycle, and directed cases pin the
// model with hand-computed values.
module tb_dp_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_LUI = 5, C_JAL = 6;
    localparam int C_TMR = 7, C_BAD = 8;

    // Strobe bit positions in the packed strobe vector
    localparam int S_JUMP = 12, S_BEQ = 11, S_BNE = 10, S_BGE = 9, S_BLT = 8, S_LUI = 7;
    localparam int S_LB = 6, S_SW = 5, S_M2R = 4, S_RDST = 3, S_RW = 2, S_TEN = 1, S_TREN = 0;

    typedef struct {
        logic [2:0]  st;
        logic [31:0] pc;
        logic        ack;
        logic [12:0] strb;
        logic        dec;
        logic [31:0] ir;
    } rec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dp_sequencer_if bus ();

    dp_sequencer #(
        .RESET_PC (RESET_PC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [12:0] act_strb;
    assign act_strb = {bus.jump, bus.beq_cntrl, bus.bneq_cntrl, bus.bgeq_cntrl, bus.blt_cntrl,
                       bus.lui_cntrl, bus.lb, bus.sw, bus.mem_to_reg, bus.reg_dst,
                       bus.reg_write, bus.timer_en, bus.timer_reg_en};

    int n_pass = 0;
    int n_total = 0;
    rec_t exp_q[$];
    logic [31:0] m_pc = RESET_PC;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- model ----------------
    function automatic int cls_of(input logic [31:0] w);
        case (w[6:0])
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b0000011: return C_LD;
            7'b0100011: return C_ST;
            7'b1100011: return C_BR;
            7'b0110111: return C_LUI;
            7'b1101111: return C_JAL;
            7'b0001011: return C_TMR;
            default:    return C_BAD;
        endcase
    endfunction

    function automatic logic [31:0] m_imm_i(input logic [31:0] w);
        logic signed [11:0] t;
        int v;
        t = w[31:20];
        v = t;
        return v;
    endfunction

    function automatic logic [31:0] m_imm_s(input logic [31:0] w);
        logic signed [11:0] t;
        int v;
        t = {w[31:25], w[11:7]};
        v = t;
        return v;
    endfunction

    function automatic logic [31:0] m_imm_b(input logic [31:0] w);
        logic signed [12:0] t;
        int v;
        t = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        v = t;
        return v;
    endfunction

    function automatic logic [31:0] m_imm_j(input logic [31:0] w);
        logic signed [20:0] t;
        int v;
        t = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        v = t;
        return v;
    endfunction

    function automatic logic [5:0] m_alu(input logic [31:0] w);
        int  c;
        int  f3;
        logic f7;
        c  = cls_of(w);
        f3 = int'(w[14:12]);
        f7 = (c == C_R || (c == C_I && (f3 == 1 || f3 == 5))) ? w[30] : 1'b0;
        return {w[5], f7, w[14:12], (c == C_BR)};
    endfunction

    // cond = {beq, bneq, bge, blt}
    function automatic logic m_taken(input logic [31:0] w, input logic [3:0] cond);
        case (int'(w[14:12]))
            0:       return cond[3];
            1:       return cond[2];
            5:       return cond[1];
            4:       return cond[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic rec_t mk(input logic [2:0] st, input logic ack, input logic [12:0] s,
                                input logic d, input logic [31:0] w);
        rec_t r;
        r.st = st; r.pc = m_pc; r.ack = ack; r.strb = s; r.dec = d; r.ir = w;
        return r;
    endfunction

    // One cycle: drive inputs just after the edge and queue that cycle's expectation
    task automatic step(input logic [31:0] w, input logic v, input logic mr,
                        input logic [3:0] c, input rec_t r);
        @(posedge clk);
        #1;
        bus.instr       = w;
        bus.instr_valid = v;
        bus.mem_ready   = mr;
        {bus.beq, bus.bneq, bus.bge, bus.blt} = c;
        exp_q.push_back(r);
    endtask

    // Run one instruction end to end. abort_mem >= 0 stops after that many MEM
    // cycles; trap_n is the number of TRAP cycles observed for an illegal opcode;
    // cnd < 0 picks random branch conditions.
    task automatic issue(input logic [31:0] w, input int vdelay, input int mwait,
                         input int abort_mem, input int trap_n, input int cnd);
        int c;
        logic [3:0] cond;
        logic [12:0] s;
        c    = cls_of(w);
        cond = (cnd < 0) ? 4'($urandom) : 4'(cnd);
        for (int i = 0; i < vdelay; i++)
            step($urandom, 1'b0, 1'($urandom), 4'($urandom), mk(3'd0, 1'b0, '0, 1'b0, w));
        step(w, 1'b1, 1'($urandom), 4'($urandom), mk(3'd0, 1'b1, '0, 1'b0, w));
        step($urandom, 1'($urandom), 1'($urandom), 4'($urandom), mk(3'd1, 1'b0, '0, 1'b1, w));
        if (c == C_BAD) begin
            for (int i = 0; i < trap_n; i++)
                step($urandom, 1'($urandom), 1'($urandom), 4'($urandom),
                     mk(3'd7, 1'b0, '0, 1'b1, w));
            return;
        end
        s = '0;
        if (c == C_BR) begin
            case (int'(w[14:12]))
                0: s[S_BEQ] = 1'b1;
                1: s[S_BNE] = 1'b1;
                5: s[S_BGE] = 1'b1;
                4: s[S_BLT] = 1'b1;
                default: ;
            endcase
        end
        s[S_LUI]  = (c == C_LUI);
        s[S_JUMP] = (c == C_JAL);
        s[S_TEN]  = (c == C_TMR);
        s[S_TREN] = (c == C_TMR);
        step($urandom, 1'($urandom), 1'($urandom), cond, mk(3'd2, 1'b0, s, 1'b1, w));
        if (c == C_BR) begin
            m_pc = m_pc + (m_taken(w, cond) ? m_imm_b(w) : 32'd4);
            return;
        end
        if (c == C_TMR) begin
            m_pc = m_pc + 32'd4;
            return;
        end
        if (c == C_LD || c == C_ST) begin
            s = '0;
            s[S_LB] = (c == C_LD);
            s[S_SW] = (c == C_ST);
            for (int i = 0; i < mwait; i++) begin
                if (i == abort_mem) return;
                step($urandom, 1'($urandom), 1'b0, 4'($urandom), mk(3'd3, 1'b0, s, 1'b1, w));
            end
            step($urandom, 1'($urandom), 1'b1, 4'($urandom), mk(3'd3, 1'b0, s, 1'b1, w));
            if (c == C_ST) begin
                m_pc = m_pc + 32'd4;
                return;
            end
        end
        s = '0;
        s[S_RW]   = (w[11:7] != 5'd0);
        s[S_M2R]  = (c == C_LD);
        s[S_RDST] = (c == C_R);
        s[S_LUI]  = (c == C_LUI);
        s[S_JUMP] = (c == C_JAL);
        step($urandom, 1'($urandom), 1'($urandom), 4'($urandom), mk(3'd4, 1'b0, s, 1'b1, w));
        m_pc = m_pc + ((c == C_JAL) ? m_imm_j(w) : 32'd4);
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin : cmp
        rec_t r;
        if (exp_q.size() != 0) begin
            r = exp_q.pop_front();
            chk("state", 32'(bus.state), 32'(r.st));
            chk("pc", bus.pc, r.pc);
            chk("instr_ack", 32'(bus.instr_ack), 32'(r.ack));
            chk("strobes", 32'(act_strb), 32'(r.strb));
            if (r.dec) begin
                chk("rs1", 32'(bus.read_reg_num1), 32'(r.ir[19:15]));
                chk("rs2", 32'(bus.read_reg_num2), 32'(r.ir[24:20]));
                chk("rd", 32'(bus.write_reg_num), 32'(r.ir[11:7]));
                chk("shamt", 32'(bus.shamt), 32'(r.ir[23:20]));
                chk("alu_cntrl", 32'(bus.alu_cntrl), 32'(m_alu(r.ir)));
                chk("imm_val", bus.imm_val,
                    (cls_of(r.ir) == C_ST) ? m_imm_s(r.ir) : m_imm_i(r.ir));
                chk("imm_val_lui", bus.imm_val_lui, r.ir & 32'hFFFF_F000);
                chk("imm_val_jump", bus.imm_val_jump, m_imm_j(r.ir));
                chk("return_address", bus.return_address, r.pc + 32'd4);
            end
        end
    end

    // ---------------- event monitor for directed checks ----------------
    int since_ack = 0, rw_cyc = -1, rw_cnt = 0, lb_cnt = 0, m2r_cnt = 0, beq_cnt = 0;
    logic [31:0] ack_pc = '0, jal_ra = '0;
    logic [4:0] rw_rd = '0;

    always @(negedge clk) begin
        if (bus.instr_ack) begin
            since_ack = 0;
            ack_pc = bus.pc;
        end else begin
            since_ack++;
        end
        if (bus.reg_write) begin
            rw_cyc = since_ack;
            rw_rd  = bus.write_reg_num;
            rw_cnt++;
        end
        if (bus.lb) lb_cnt++;
        if (bus.mem_to_reg) m2r_cnt++;
        if (bus.beq_cntrl) beq_cnt++;
        if (bus.jump && bus.state == 3'd4) jal_ra = bus.return_address;
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"}, 32'(bus.state), 32'd0);
        chk({tag, "_pc"}, bus.pc, RESET_PC);
        chk({tag, "_ack"}, 32'(bus.instr_ack), 32'd0);
        chk({tag, "_strobes"}, 32'(act_strb), 32'd0);
        chk({tag, "_regs"}, 32'({bus.read_reg_num1, bus.read_reg_num2, bus.write_reg_num}), 0);
        chk({tag, "_alu"}, 32'({bus.alu_cntrl, bus.shamt}), 32'd0);
        chk({tag, "_imm"}, bus.imm_val | bus.imm_val_lui | bus.imm_val_jump, 32'd0);
        chk({tag, "_ra"}, bus.return_address, 32'd0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #1;
        reset = 1'b0;
        bus.instr_valid = 1'b1;
        #1;
        chk_reset_outputs("rst_async");
        repeat (n) @(posedge clk);
        #1;
        chk_reset_outputs("rst_hold");
        bus.instr_valid = 1'b0;
        reset = 1'b1;
        m_pc = RESET_PC;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 8))
            0: w[6:0] = 7'b0110011;
            1: w[6:0] = 7'b0010011;
            2: w[6:0] = 7'b0000011;
            3: w[6:0] = 7'b0100011;
            4: w[6:0] = 7'b1100011;
            5: w[6:0] = 7'b0110111;
            6: w[6:0] = 7'b1101111;
            7: w[6:0] = 7'b0001011;
            default: ;
        endcase
        return w;
    endfunction

    localparam logic [31:0] ADDI_X1_5 = 32'h0050_0093;
    localparam logic [31:0] BEQ_P8    = 32'h0000_0463;
    localparam logic [31:0] JAL_X1    = 32'h1000_00EF;
    localparam logic [31:0] LW_X2     = 32'h0000_A103;
    localparam logic [31:0] SW_X2     = 32'h0020_A023;
    localparam logic [31:0] ILLEGAL   = 32'h0000_007F;

    initial begin
        bus.instr = '0; bus.instr_valid = 1'b0; bus.mem_ready = 1'b0;
        bus.beq = 1'b0; bus.bneq = 1'b0; bus.bge = 1'b0; bus.blt = 1'b0;
        do_reset(3);

        // ADDI x1,x0,5: ack in cycle 0, reg_write to x1 in cycle 3, pc 0 -> 4
        issue(ADDI_X1_5, 0, 0, -1, 0, -1);
        @(negedge clk); #1;
        chk("addi_rw_cycle", 32'(rw_cyc), 32'd3);
        chk("addi_rw_rd", 32'(rw_rd), 32'd1);
        issue(ADDI_X1_5, 1, 0, -1, 0, -1);
        chk("addi_next_pc", ack_pc, 32'h4);
        issue(ADDI_X1_5, 0, 0, -1, 0, -1);
        issue(ADDI_X1_5, 2, 0, -1, 0, -1);

        // BEQ +8 at 0x10 taken, then at 0x18 not taken
        beq_cnt = 0;
        rw_cnt = 0;
        issue(BEQ_P8, 0, 0, -1, 0, 4'b1000);
        chk("beq_at_0x10", ack_pc, 32'h10);
        issue(BEQ_P8, 0, 0, -1, 0, 4'b0111);
        chk("beq_taken_pc", ack_pc, 32'h18);
        issue(ADDI_X1_5, 0, 0, -1, 0, -1);
        chk("beq_nt_pc", ack_pc, 32'h1C);
        chk("beq_strobe_cnt", 32'(beq_cnt), 32'd2);
        chk("beq_rw_cnt", 32'(rw_cnt), 32'd1);

        // JAL x1,+0x100 at 0x20, then LW with five wait cycles at 0x120
        issue(JAL_X1, 0, 0, -1, 0, -1);
        @(negedge clk); #1;
        chk("jal_ra", jal_ra, 32'h24);
        lb_cnt = 0;
        m2r_cnt = 0;
        issue(LW_X2, 0, 5, -1, 0, -1);
        @(negedge clk); #1;
        chk("jal_target_pc", ack_pc, 32'h120);
        chk("lw_lb_cycles", 32'(lb_cnt), 32'd6);
        chk("lw_m2r_cycles", 32'(m2r_cnt), 32'd1);

        // Reset in the middle of a SW memory wait
        issue(SW_X2, 0, 50, 3, 0, -1);
        @(negedge clk); #1;
        chk("sw_waiting", 32'(bus.sw), 32'd1);
        rw_cnt = 0;
        reset = 1'b0;
        #1;
        chk("abort_sw", 32'(bus.sw), 32'd0);
        chk("abort_pc", bus.pc, RESET_PC);
        chk("abort_state", 32'(bus.state), 32'd0);
        bus.instr_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        m_pc = RESET_PC;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_rw", 32'(rw_cnt), 32'd0);

        // Illegal opcode at pc 8 traps; pc frozen for 20 cycles, then reset
        issue(ADDI_X1_5, 0, 0, -1, 0, -1);
        issue(ADDI_X1_5, 0, 0, -1, 0, -1);
        issue(ILLEGAL, 1, 0, -1, 20, -1);
        @(negedge clk); #1;
        chk("trap_state", 32'(bus.state), 32'd7);
        chk("trap_pc", bus.pc, 32'h8);
        do_reset(2);

        // Randomized instruction stream
        for (int n = 0; n < 400; n++) begin
            logic [31:0] w;
            w = rand_instr();
            if (cls_of(w) == C_BAD) begin
                issue(w, $urandom_range(0, 2), 0, -1, $urandom_range(1, 4), -1);
                do_reset(1);
            end else begin
                issue(w, $urandom_range(0, 2), $urandom_range(0, 4), -1, 0, -1);
            end
        end

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) chk("trace_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
